alu_mul_iter: RTL
=================

Name: alu_mul_iter

Overview:
Parametrised iterative radix-2^R shift-add multiplier for the EX stage. It replaces the fixed 64-cycle MUL/MULW unit. It covers the full RV64M multiply set (MUL, MULH, MULHSU, MULHU, MULW) and has three features the old unit lacks:
- valid/ready handshakes on input and output;
- early termination when the remaining multiplier bits are zero;
- a pipeline flush.

The EX stage stalls on in_ready/out_valid instead of a private stall counter.

Parameters:
XLEN, 64, operand/result width; must be even and divisible by RADIX_BITS.
RADIX_BITS, 2, multiplier bits consumed per CALC cycle (1, 2 or 4).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  abort in-flight op, discard result
in_valid  in  1  op request
in_ready  out  1  unit can accept op
op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal
a  in  XLEN  multiplicand (rs1)
b  in  XLEN  multiplier (rs2)
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  XLEN  final value
busy  out  1  state != IDLE

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset. On reset:
  - state goes to IDLE;
  - out_valid=0, result=0, busy=0, all internal registers cleared;
  - in_ready=1 from the cycle after reset deasserts.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready.
- On accept, latch the operands as follows:
  - Signedness: a is signed for MULH and MULHSU; b is signed for MULH only; MUL, MULHU and MULW are treated as unsigned.
  - mcand and mplier hold the magnitudes of a and b. Magnitude of the most negative value = 2^(XLEN-1), unsigned.
  - neg = (a signed && a[XLEN-1]) XOR (b signed && b[XLEN-1]).
  - MULW uses a[31:0] and b[31:0], zero-extended.
  - The 2*XLEN-bit accumulator is cleared; go to CALC.
- Illegal op: accepted, goes straight to DONE with result=0, no CALC cycles.
- Each CALC cycle:
  - acc += (mcand * mplier[R-1:0]) << shift;
  - mplier >>= R; shift += R; step counter++.
- Leave CALC after the cycle where either of these holds:
  - the post-shift mplier == 0 (early termination), or
  - step count reaches XLEN/R (MULW: (XLEN/2)/R).
- CALC cycles N = max(1, ceil(index of highest set mplier bit+1 / R)). Default maximum is 32 (MULW 16).
- On the last CALC cycle, register the result. Let p = neg ? -acc : acc (2*XLEN-bit two's complement):
  - MUL: p[XLEN-1:0];
  - MULH, MULHSU, MULHU: p[2*XLEN-1:XLEN];
  - MULW: p[31:0], sign-extended from bit 31.
  - Then go to DONE.
- DONE:
  - out_valid=1; result is held stable while out_ready=0 (backpressure).
  - On out_valid && out_ready, go to IDLE next cycle; no same-cycle re-accept.
- Latency: accept edge, then N CALC cycles, then out_valid high in the following cycle. Minimum accept-to-out_valid is 2 edges.
- flush (any state): state goes to IDLE next edge, out_valid drops, result is not delivered.
  - flush in the same cycle as in_valid means no accept.
  - flush has priority over out_ready.
- reset takes priority over flush and over everything else, mid-operation included.
- result is not required to be zeroed after a handshake, but must be 0 after reset.

Test Plan:
- MUL a=3, b=5 -> out_valid after 2 CALC cycles (R=2), result=15; a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF MUL -> result=1 after 32 CALC cycles.
- MULH a=-1, b=-1 -> 0; MULHU a=0xFFFFFFFFFFFFFFFF, b=2 -> 1; MULHSU a=-1, b=2 -> 0xFFFFFFFFFFFFFFFF; MULH a=0x8000000000000000, b=0x8000000000000000 -> 0x4000000000000000.
- MULW a=0x7FFFFFFF, b=2 -> 0xFFFFFFFFFFFFFFFE; MULW a=0x1_00000003, b=0x5_00000004 -> 12 within at most 16 CALC cycles.
- Early termination: b=0 -> N=1, out_valid 2 edges after accept, result 0; b=1 -> N=1; b=0x8000000000000000 (MULHU) -> N=32.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0, second in_valid not accepted; release -> IDLE, next op accepted.
- flush at CALC step 10 and reset at CALC step 10 -> IDLE next edge, out_valid never pulses, following MUL 7*6=42 correct; op=5 -> result 0, out_valid after 1 edge.

Source files
------------

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative radix-2^RADIX_BITS shift-add multiplier for the EX stage.
// Handles MUL, MULH, MULHSU, MULHU and MULW. It terminates early once the remaining
// multiplier bits are all zero. Inputs and outputs use valid/ready handshakes, and a
// flush input aborts the current operation.
//
// Ports:
//   clk       - clock
//   reset     - synchronous active-high reset
//   flush     - abort in-flight op; its result is discarded
//   in_valid  - op request
//   in_ready  - unit can accept an op (IDLE and no flush)
//   op        - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal (result 0)
//   a, b      - multiplicand (rs1), multiplier (rs2)
//   out_valid - result valid (DONE state)
//   out_ready - consumer takes the result
//   result    - final value, held stable under backpressure
//   busy      - state != IDLE
module alu_mul_iter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned HALF   = XLEN / 2;
  localparam int unsigned STEP_W = $clog2(XLEN / RADIX_BITS + 1);
  localparam int unsigned SH_W   = $clog2(XLEN);

  localparam logic [STEP_W-1:0] STEPS_FULL = STEP_W'(XLEN / RADIX_BITS);
  localparam logic [STEP_W-1:0] STEPS_HALF = STEP_W'(HALF / RADIX_BITS);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                neg_q, neg_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_sgn, b_sgn;
  logic [XLEN-1:0]     a_op, b_op, a_mag, b_mag;
  logic [2*XLEN-1:0]   pp, acc_sum, prod;
  logic [XLEN-1:0]     mplier_sh, res_sel;
  logic [STEP_W-1:0]   step_inc, step_max;
  logic                last;

  assign in_ready  = (state_q == IDLE) && !flush && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

  // Operand conditioning at accept time.
  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
    b_sgn = (op == OP_MULH);
    a_op  = (op == OP_MULW) ? {{HALF{1'b0}}, a[HALF-1:0]} : a;
    b_op  = (op == OP_MULW) ? {{HALF{1'b0}}, b[HALF-1:0]} : b;
    // Negating the most negative value wraps back to itself. Read as unsigned,
    // that pattern is 2^(XLEN-1), which is the magnitude we want.
    a_mag = (a_sgn && a_op[XLEN-1]) ? -a_op : a_op;
    b_mag = (b_sgn && b_op[XLEN-1]) ? -b_op : b_op;
  end

  // One radix digit per CALC cycle.
  always_comb begin
    pp        = {{XLEN{1'b0}}, mcand_q} *
                {{(2*XLEN-RADIX_BITS){1'b0}}, mplier_q[RADIX_BITS-1:0]};
    acc_sum   = acc_q + (pp << shift_q);
    mplier_sh = mplier_q >> RADIX_BITS;
    step_inc  = step_q + STEP_W'(1);
    step_max  = (op_q == OP_MULW) ? STEPS_HALF : STEPS_FULL;
    last      = (mplier_sh == '0) || (step_inc == step_max);
    // Sign is applied once, to the full-width magnitude product.
    prod      = neg_q ? -acc_sum : acc_sum;
    unique case (op_q)
      OP_MUL:                       res_sel = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_sel = prod[2*XLEN-1:XLEN];
      OP_MULW:                      res_sel = {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
      default:                      res_sel = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    shift_d  = shift_q;
    step_d   = step_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d     = op;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = (a_sgn && a_op[XLEN-1]) ^ (b_sgn && b_op[XLEN-1]);
          acc_d    = '0;
          shift_d  = '0;
          step_d   = '0;
          if (op > OP_MULW) begin
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mplier_d = mplier_sh;
        shift_d  = shift_q + SH_W'(RADIX_BITS);
        step_d   = step_inc;
        if (last) begin
          result_d = res_sel;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      shift_q  <= '0;
      step_q   <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      shift_q  <= shift_d;
      step_q   <= step_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule
